// File: rtl/conv_feeder_pkg.sv
// conv_feeder_pkg: shared widths, tile sizes, counter limits and FSM states for conv_tile_feeder
package conv_feeder_pkg;
  localparam int DATA_W_DEF = 8;
  localparam int ACC_W_DEF = 32;
  localparam int N_ACT = 9;
  localparam int N_WGT = 4;
  localparam int N_RES = 4;
  localparam int CNT_W = $clog2(N_ACT);
  localparam int WI_W = $clog2(N_WGT);
  localparam int IDX_W = $clog2(N_RES);
  localparam logic [CNT_W-1:0] ACT_LAST = CNT_W'(N_ACT - 1);
  localparam logic [CNT_W-1:0] WGT_LAST = CNT_W'(N_WGT - 1);
  localparam logic [IDX_W-1:0] RES_LAST = IDX_W'(N_RES - 1);
  typedef enum logic [2:0] {LOAD_ACT, LOAD_WGT, DRIVE, CAPTURE, DRAIN} state_t;
endpackage

// File: rtl/conv_res_serializer.sv
// conv_res_serializer: buffers the 4 array results on load and emits them on a valid/ready stream
//   in : clk, reset (sync, high), load (capture pulse), res[N_RES] (array results), m_ready
//   out: m_valid, m_data (res[idx]), m_last (idx==N_RES-1), done (last word handshake)
module conv_res_serializer
  import conv_feeder_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           load,
  input  logic [N_RES-1:0][ACC_W-1:0]    res,
  output logic                           m_valid,
  input  logic                           m_ready,
  output logic [ACC_W-1:0]               m_data,
  output logic                           m_last,
  output logic                           done
);
  logic [N_RES-1:0][ACC_W-1:0] buf_q, buf_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic valid_q, valid_d, fire;
  always_comb begin
    fire = valid_q && m_ready;
    done = fire && idx_q == RES_LAST;
    buf_d = load ? res : buf_q;
    idx_d = load ? '0 : fire ? idx_q + 1'b1 : idx_q;
    valid_d = load || (valid_q && !done);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      buf_q <= '0;
      idx_q <= '0;
      valid_q <= 1'b0;
    end else begin
      buf_q <= buf_d;
      idx_q <= idx_d;
      valid_q <= valid_d;
    end
  end
  assign m_valid = valid_q;
  assign m_data = buf_q[idx_q];
  assign m_last = valid_q && idx_q == RES_LAST;
endmodule

// File: rtl/conv_tile_feeder.sv
// conv_tile_feeder: serial byte stream -> parallel systolic array inputs -> serial result stream
//   in : clk, reset (sync, high), s_valid, s_data (9 act then 4 wgt bytes), arr_res[4], m_ready
//   out: s_ready, arr_act[9], arr_wgt[4] (registered, frozen while the array computes),
//        m_valid, m_data, m_last, busy
//   CONV_FEEDER_WREUSE_EN adds input wgt_reload; when low on a tile's first byte and weights
//   were loaded since reset, the weight bytes are skipped and arr_wgt is reused.
module conv_tile_feeder
  import conv_feeder_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int ACC_W     = ACC_W_DEF,
  parameter int ARRAY_LAT = 3
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           s_valid,
  output logic                           s_ready,
  input  logic [DATA_W-1:0]              s_data,
  output logic [N_ACT-1:0][DATA_W-1:0]   arr_act,
  output logic [N_WGT-1:0][DATA_W-1:0]   arr_wgt,
  input  logic [N_RES-1:0][ACC_W-1:0]    arr_res,
  output logic                           m_valid,
  input  logic                           m_ready,
  output logic [ACC_W-1:0]               m_data,
  output logic                           m_last,
`ifdef CONV_FEEDER_WREUSE_EN
  input  logic                           wgt_reload,
`endif
  output logic                           busy
);
  localparam int LAT_W = $clog2(ARRAY_LAT + 1);
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(ARRAY_LAT - 1);
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [LAT_W-1:0] lat_q, lat_d;
  logic [N_ACT-1:0][DATA_W-1:0] act_q, act_d;
  logic [N_WGT-1:0][DATA_W-1:0] wgt_q, wgt_d;
  logic s_fire, capture, drain_done, skip_wgt;
  assign s_ready = state_q == LOAD_ACT || state_q == LOAD_WGT;
  assign s_fire = s_valid && s_ready;
  assign busy = !(state_q == LOAD_ACT && cnt_q == '0);
  assign arr_act = act_q;
  assign arr_wgt = wgt_q;
`ifdef CONV_FEEDER_WREUSE_EN
  logic skip_q, skip_d, wld_q, wld_d, first_act, wgt_done;
  always_comb begin
    first_act = state_q == LOAD_ACT && s_fire && cnt_q == '0;
    wgt_done = state_q == LOAD_WGT && s_fire && cnt_q == WGT_LAST;
    skip_d = first_act ? !wgt_reload && wld_q : skip_q;
    wld_d = wld_q || wgt_done;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      skip_q <= 1'b0;
      wld_q <= 1'b0;
    end else begin
      skip_q <= skip_d;
      wld_q <= wld_d;
    end
  end
  assign skip_wgt = skip_q;
`else
  assign skip_wgt = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    lat_d = lat_q;
    act_d = act_q;
    wgt_d = wgt_q;
    capture = 1'b0;
    unique case (state_q)
      LOAD_ACT: if (s_fire) begin
        act_d[cnt_q] = s_data;
        cnt_d = cnt_q == ACT_LAST ? '0 : cnt_q + 1'b1;
        if (cnt_q == ACT_LAST) state_d = skip_wgt ? DRIVE : LOAD_WGT;
      end
      LOAD_WGT: if (s_fire) begin
        wgt_d[cnt_q[WI_W-1:0]] = s_data;
        cnt_d = cnt_q == WGT_LAST ? '0 : cnt_q + 1'b1;
        if (cnt_q == WGT_LAST) state_d = DRIVE;
      end
      DRIVE: begin
        lat_d = lat_q == LAT_LAST ? '0 : lat_q + 1'b1;
        if (lat_q == LAT_LAST) state_d = CAPTURE;
      end
      CAPTURE: begin
        capture = 1'b1;
        state_d = DRAIN;
      end
      DRAIN: if (drain_done) state_d = LOAD_ACT;
      default: state_d = LOAD_ACT;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= LOAD_ACT;
      cnt_q <= '0;
      lat_q <= '0;
      act_q <= '0;
      wgt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      lat_q <= lat_d;
      act_q <= act_d;
      wgt_q <= wgt_d;
    end
  end
  conv_res_serializer #(.ACC_W(ACC_W)) u_ser (
    .clk(clk),
    .reset(reset),
    .load(capture),
    .res(arr_res),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_data(m_data),
    .m_last(m_last),
    .done(drain_done)
  );
endmodule

// File: tb/tb_conv_tile_feeder.sv
// tb_conv_tile_feeder: table vectors, corner sequences and random tiles against a conv reference model
module tb_conv_tile_feeder;
  import conv_feeder_pkg::*;
  localparam int DW = 8;
  localparam int AW = 32;
  localparam int LAT = 3;
`ifdef CONV_FEEDER_WREUSE_EN
  localparam bit WREUSE = 1'b1;
  logic wgt_reload = 1'b1;
`else
  localparam bit WREUSE = 1'b0;
`endif
  typedef struct {
    logic [N_ACT-1:0][DW-1:0] act;
    logic [N_WGT-1:0][DW-1:0] wgt;
    logic reload;
    logic rnd;
    int gap;
    logic [N_RES-1:0][AW-1:0] exp;
  } vec_t;
  logic clk = 1'b0, reset = 1'b1, s_valid = 1'b0, m_ready = 1'b1, rnd_rdy = 1'b0;
  logic s_ready, m_valid, m_last, busy;
  logic [DW-1:0] s_data = '0;
  logic [N_ACT-1:0][DW-1:0] arr_act, r_act;
  logic [N_WGT-1:0][DW-1:0] arr_wgt, r_wgt, m_w;
  logic [N_RES-1:0][AW-1:0] arr_res, p1, p2, p3;
  logic [AW-1:0] m_data, sd, e;
  logic [AW-1:0] exp_q[$];
  logic m_wld = 1'b0, stall = 1'b0, sl = 1'b0;
  int cyc = 0, vectors = 0, miscompares = 0;
  int tiles_sent = 0, tiles_done = 0, lat_seen = 0, t_last = 0, widx = 0, got = 0, g0 = 0;
  vec_t tv[4];
  vec_t vt;
  conv_tile_feeder #(.DATA_W(DW), .ACC_W(AW), .ARRAY_LAT(LAT)) dut (
    .clk(clk),
    .reset(reset),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .s_data(s_data),
    .arr_act(arr_act),
    .arr_wgt(arr_wgt),
    .arr_res(arr_res),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_data(m_data),
    .m_last(m_last),
`ifdef CONV_FEEDER_WREUSE_EN
    .wgt_reload(wgt_reload),
`endif
    .busy(busy)
  );
  always #5 clk = ~clk;
  function automatic logic [AW-1:0] conv(input logic [N_ACT-1:0][DW-1:0] a,
                                         input logic [N_WGT-1:0][DW-1:0] w, input int r);
    int s = 0;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++)
        s += int'(a[(r / 2 + i) * 3 + r % 2 + j]) * int'(w[i * 2 + j]);
    return AW'(s);
  endfunction
  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int r = 0; r < N_RES; r++) p1[r] <= conv(arr_act, arr_wgt, r);
    p2 <= p1;
    p3 <= p2;
  end
  assign arr_res = p3;
  task automatic check(input string name, input logic [AW-1:0] got_v, input logic [AW-1:0] want);
    vectors++;
    if (got_v !== want) begin
      miscompares++;
      $display("FAIL %s: got %0d (0x%08h) want %0d (0x%08h)", name, got_v, got_v, want, want);
    end
  endtask
  task automatic fail_now(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: got timeout or unexpected event, want none", name);
  endtask
  task automatic send_byte(input logic [DW-1:0] b, input int gap);
    logic ok = 1'b0;
    repeat ($urandom_range(gap, 0)) begin
      s_valid = 1'b0;
      @(posedge clk); #1;
    end
    s_valid = 1'b1;
    s_data = b;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      ok = s_ready;
      @(posedge clk); #1;
    end
    if (!ok) fail_now("s_ready_timeout");
    s_valid = 1'b0;
  endtask
  task automatic send_tile(input logic [N_ACT-1:0][DW-1:0] act, input logic [N_WGT-1:0][DW-1:0] wgt,
                           input logic reload, input int gap, input logic use_model,
                           input logic [N_RES-1:0][AW-1:0] exp);
    logic skip;
    skip = WREUSE && m_wld && !reload;
    if (!skip) begin
      m_w = wgt;
      m_wld = 1'b1;
    end
`ifdef CONV_FEEDER_WREUSE_EN
    wgt_reload = reload;
`endif
    for (int k = 0; k < N_ACT; k++) send_byte(act[k], gap);
    if (!skip) for (int k = 0; k < N_WGT; k++) send_byte(wgt[k], gap);
    for (int r = 0; r < N_RES; r++) exp_q.push_back(use_model ? conv(act, m_w, r) : exp[r]);
    t_last = cyc;
    tiles_sent++;
  endtask
  task automatic wait_idle();
    int n = 0;
    while (tiles_done != tiles_sent && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    if (tiles_done != tiles_sent) fail_now("drain_timeout");
    else check("busy_idle", AW'(busy), 0);
  endtask
  task automatic run_vec(input vec_t v);
    rnd_rdy = v.rnd;
    send_tile(v.act, v.wgt, v.reload, v.gap, 1'b0, v.exp);
    wait_idle();
    rnd_rdy = 1'b0;
  endtask
  task automatic do_reset();
    reset = 1'b1;
    s_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    tiles_sent = tiles_done;
    lat_seen = tiles_sent;
    widx = 0;
    exp_q.delete();
    m_wld = 1'b0;
    @(negedge clk);
    check("rst_s_ready", AW'(s_ready), 1);
    check("rst_m_valid", AW'(m_valid), 0);
    check("rst_m_last", AW'(m_last), 0);
    check("rst_busy", AW'(busy), 0);
    check("rst_arr_act", AW'(arr_act == '0), 1);
    check("rst_arr_wgt", AW'(arr_wgt == '0), 1);
    @(posedge clk); #1;
  endtask
  initial begin
    fork
      forever begin
        @(posedge clk); #1;
        m_ready = rnd_rdy ? 1'($urandom_range(1, 0)) : 1'b1;
      end
      forever begin
        @(negedge clk);
        if (reset) stall = 1'b0;
        else begin
          if (stall) begin
            check("stall_valid", AW'(m_valid), 1);
            check("stall_data", m_data, sd);
            check("stall_last", AW'(m_last), AW'(sl));
          end
          if (tiles_sent != tiles_done) check("s_ready_busy", AW'(s_ready), 0);
          else check("stray_valid", AW'(m_valid), 0);
          if (m_valid && lat_seen != tiles_sent) begin
            check("latency", AW'(cyc - t_last), AW'(LAT + 1));
            lat_seen = tiles_sent;
          end
          if (m_valid && m_ready) begin
            if (exp_q.size() == 0) fail_now("unexpected_word");
            else begin
              e = exp_q.pop_front();
              check("m_data", m_data, e);
              check("m_last", AW'(m_last), AW'(widx == N_RES - 1));
              got++;
              if (widx == N_RES - 1) begin
                widx = 0;
                tiles_done++;
              end else widx++;
            end
          end
          stall = m_valid && !m_ready;
          sd = m_data;
          sl = m_last;
        end
      end
      begin
        tv[0] = '{act: {8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1},
                  wgt: {8'd1, 8'd0, 8'd0, 8'd1}, reload: 1'b1, rnd: 1'b0, gap: 0,
                  exp: {32'd14, 32'd12, 32'd8, 32'd6}};
        tv[1] = '{act: {N_ACT{8'd255}}, wgt: {N_WGT{8'd255}}, reload: 1'b1, rnd: 1'b0, gap: 0,
                  exp: {N_RES{32'h0003F804}}};
        tv[2] = tv[0];
        tv[2].rnd = 1'b1;
        tv[2].gap = 3;
        tv[3] = '{act: {8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9},
                  wgt: {8'd1, 8'd0, 8'd0, 8'd1}, reload: 1'b1, rnd: 1'b0, gap: 0,
                  exp: {32'd6, 32'd8, 32'd12, 32'd14}};
        do_reset();
        for (int i = 0; i < 3; i++) run_vec(tv[i]);
        for (int k = 0; k < 5; k++) send_byte(tv[0].act[k], 0);
        @(negedge clk);
        check("busy_mid", AW'(busy), 1);
        check("arr_act_mid", AW'(arr_act[4]), 5);
        @(posedge clk); #1;
        do_reset();
        run_vec(tv[0]);
        send_tile(tv[0].act, tv[0].wgt, 1'b1, 0, 1'b0, tv[0].exp);
        g0 = got;
        for (int i = 0; i < 100 && got < g0 + 2; i++) @(posedge clk);
        if (got < g0 + 2) fail_now("drain_wait");
        #1;
        do_reset();
        run_vec(tv[3]);
`ifdef CONV_FEEDER_WREUSE_EN
        do_reset();
        run_vec(tv[0]);
        vt = tv[3];
        vt.reload = 1'b0;
        vt.wgt = '0;
        run_vec(vt);
        check("wgt_reused", AW'(arr_wgt == tv[0].wgt), 1);
`endif
        for (int t = 0; t < 20; t++) begin
          for (int k = 0; k < N_ACT; k++) r_act[k] = 8'($urandom);
          for (int k = 0; k < N_WGT; k++) r_wgt[k] = 8'($urandom);
          rnd_rdy = 1'b1;
          send_tile(r_act, r_wgt, 1'($urandom_range(1, 0)), 2, 1'b1, '0);
          wait_idle();
          rnd_rdy = 1'b0;
        end
      end
    join_any
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
